fir_tap_engine: RTL and testbench

//  FIR compute engine and the producer/consumer of the two 11-entry synchronous BRAMs (tap RAM, data RAM).

---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_mac.sv | 57 +++++
 rtl/fir_tap_engine.sv | 175 +++++++++++++++++
 tb/tb_fir_tap_engine.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR tap engine.
package fir_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StWaitIn,
        StCalc,
        StOut,
        StDone
    } state_e;

    localparam int unsigned NUM_TAP_DEFAULT = 11;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned PTR_WIDTH = cnt_width(NUM_TAP_DEFAULT);

endpackage

// File: rtl/fir_mac.sv
// Clearable multiply-accumulate for the FIR engine.
// FIR_SAT_EN: full-precision products, widened accumulator and saturated result.
module fir_mac #(
    parameter int unsigned BIT_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        en,
    input  logic signed [BIT_WIDTH-1:0] a,
    input  logic signed [BIT_WIDTH-1:0] b,
    output logic        [BIT_WIDTH-1:0] result
);

`ifdef FIR_SAT_EN
    localparam int unsigned PW = 2 * BIT_WIDTH;
    localparam int unsigned AW = PW + 4;

    logic signed [PW-1:0]           prod;
    logic signed [AW-1:0]           acc;
    logic        [AW-BIT_WIDTH:0]   hi;

    assign prod = PW'(a) * PW'(b);
    assign hi   = acc[AW-1:BIT_WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + {{4{prod[PW-1]}}, prod};
        end
    end

    // The value fits when every bit above the result's sign bit matches it.
    always_comb begin
        result = acc[BIT_WIDTH-1:0];
        if (!((&hi) || (~|hi))) begin
            result = acc[AW-1] ? {1'b1, {(BIT_WIDTH-1){1'b0}}} : {1'b0, {(BIT_WIDTH-1){1'b1}}};
        end
    end
`else
    logic [BIT_WIDTH-1:0] prod;
    logic [BIT_WIDTH-1:0] acc;

    assign prod   = a * b;
    assign result = acc;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod;
        end
    end
`endif

endmodule

// File: rtl/fir_tap_engine.sv
// FIR engine: stream in, circular data RAM, NUM_TAP MACs against tap RAM, stream out.
// Optional FIR_SAT_EN selects saturating arithmetic inside fir_mac.
module fir_tap_engine
    import fir_pkg::*;
#(
    parameter int unsigned NUM_TAP    = NUM_TAP_DEFAULT,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned BIT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ap_start,
    input  logic [31:0]           data_length,
    output logic                  ap_idle,
    output logic                  ap_done,
    input  logic                  ss_tvalid,
    input  logic [BIT_WIDTH-1:0]  ss_tdata,
    output logic                  ss_tready,
    output logic                  sm_tvalid,
    output logic [BIT_WIDTH-1:0]  sm_tdata,
    output logic                  sm_tlast,
    input  logic                  sm_tready,
    output logic                  tap_re,
    output logic [ADDR_WIDTH-1:0] tap_raddr,
    input  logic [BIT_WIDTH-1:0]  tap_rdo,
    output logic                  dat_we,
    output logic [ADDR_WIDTH-1:0] dat_waddr,
    output logic [BIT_WIDTH-1:0]  dat_wdi,
    output logic                  dat_re,
    output logic [ADDR_WIDTH-1:0] dat_raddr,
    input  logic [BIT_WIDTH-1:0]  dat_rdo
);

    localparam int unsigned   KW       = cnt_width(NUM_TAP + 1);
    localparam logic [KW-1:0] N        = KW'(NUM_TAP);
    localparam logic [KW-1:0] LAST_IDX = KW'(NUM_TAP - 1);

    state_e        state;
    logic [KW-1:0] k;
    logic [KW-1:0] wr_ptr;
    logic [KW-1:0] rd_idx;
    logic [31:0]   len;
    logic [31:0]   count;
    logic          ss_hs;
    logic          mac_en;

    assign ss_hs  = ss_tvalid & ss_tready;
    // Newest sample sits at wr_ptr; tap k pairs with the sample k steps older.
    assign rd_idx = (wr_ptr >= k) ? (wr_ptr - k) : (wr_ptr + N - k);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            ap_idle   <= 1'b1;
            ap_done   <= 1'b0;
            ss_tready <= 1'b0;
            sm_tvalid <= 1'b0;
            sm_tlast  <= 1'b0;
            k         <= '0;
            wr_ptr    <= '0;
            len       <= '0;
            count     <= '0;
        end else begin
            ap_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (ap_start) begin
                        state   <= StClear;
                        ap_idle <= 1'b0;
                        k       <= '0;
                        wr_ptr  <= '0;
                        count   <= '0;
                        len     <= data_length;
                    end
                end
                StClear: begin
                    if (k == LAST_IDX) begin
                        k <= '0;
                        if (len == 32'd0) begin
                            state   <= StDone;
                            ap_done <= 1'b1;
                        end else begin
                            state     <= StWaitIn;
                            ss_tready <= 1'b1;
                        end
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                StWaitIn: begin
                    if (ss_hs) begin
                        state     <= StCalc;
                        ss_tready <= 1'b0;
                        k         <= '0;
                    end
                end
                StCalc: begin
                    if (k == N) begin
                        state     <= StOut;
                        sm_tvalid <= 1'b1;
                        sm_tlast  <= (count + 32'd1 == len);
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                StOut: begin
                    if (sm_tready) begin
                        sm_tvalid <= 1'b0;
                        sm_tlast  <= 1'b0;
                        wr_ptr    <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
                        count     <= count + 32'd1;
                        if (sm_tlast) begin
                            state   <= StDone;
                            ap_done <= 1'b1;
                        end else begin
                            state     <= StWaitIn;
                            ss_tready <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state   <= StIdle;
                    ap_idle <= 1'b1;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Sample write is combinational on the handshake so it lands before CALC reads.
    always_comb begin
        tap_re    = 1'b0;
        tap_raddr = '0;
        dat_re    = 1'b0;
        dat_raddr = '0;
        dat_we    = 1'b0;
        dat_waddr = '0;
        dat_wdi   = '0;
        mac_en    = 1'b0;
        unique case (state)
            StClear: begin
                dat_we    = 1'b1;
                dat_waddr = ADDR_WIDTH'(k);
            end
            StWaitIn: begin
                dat_we    = ss_hs;
                dat_waddr = ADDR_WIDTH'(wr_ptr);
                dat_wdi   = ss_tdata;
            end
            StCalc: begin
                if (k != N) begin
                    tap_re    = 1'b1;
                    tap_raddr = ADDR_WIDTH'(k);
                    dat_re    = 1'b1;
                    dat_raddr = ADDR_WIDTH'(rd_idx);
                end
                mac_en = (k != '0);
            end
            default: ;
        endcase
    end

    fir_mac #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    (ss_hs),
        .en     (mac_en),
        .a      (tap_rdo),
        .b      (dat_rdo),
        .result (sm_tdata)
    );

endmodule

// File: tb/tb_fir_tap_engine.sv
// Directed bench for fir_tap_engine with behavioural RAMs and an output scoreboard.
module tb_fir_tap_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        ap_start;
    logic [31:0] data_length;
    logic        ap_idle;
    logic        ap_done;
    logic        ss_tvalid;
    logic [31:0] ss_tdata;
    logic        ss_tready;
    logic        sm_tvalid;
    logic [31:0] sm_tdata;
    logic        sm_tlast;
    logic        sm_tready;
    logic        tap_re;
    logic [11:0] tap_raddr;
    logic [31:0] tap_rdo;
    logic        dat_we;
    logic [11:0] dat_waddr;
    logic [31:0] dat_wdi;
    logic        dat_re;
    logic [11:0] dat_raddr;
    logic [31:0] dat_rdo;

    fir_tap_engine dut (
        .clk         (clk),
        .rst         (rst),
        .ap_start    (ap_start),
        .data_length (data_length),
        .ap_idle     (ap_idle),
        .ap_done     (ap_done),
        .ss_tvalid   (ss_tvalid),
        .ss_tdata    (ss_tdata),
        .ss_tready   (ss_tready),
        .sm_tvalid   (sm_tvalid),
        .sm_tdata    (sm_tdata),
        .sm_tlast    (sm_tlast),
        .sm_tready   (sm_tready),
        .tap_re      (tap_re),
        .tap_raddr   (tap_raddr),
        .tap_rdo     (tap_rdo),
        .dat_we      (dat_we),
        .dat_waddr   (dat_waddr),
        .dat_wdi     (dat_wdi),
        .dat_re      (dat_re),
        .dat_raddr   (dat_raddr),
        .dat_rdo     (dat_rdo)
    );

    always #5 clk = ~clk;

    logic [31:0] tap_mem [0:10];
    logic [31:0] dat_mem [0:10] = '{default: 32'hDEAD_BEEF};

    always @(posedge clk) begin
        if (dat_we) dat_mem[dat_waddr[3:0]] <= dat_wdi;
        if (dat_re) dat_rdo <= dat_mem[dat_raddr[3:0]];
        if (tap_re) tap_rdo <= tap_mem[tap_raddr[3:0]];
    end

    int          cyc = 0;
    int          nvec = 0;
    int          nfail = 0;
    int          cur_len;
    logic [31:0] stim [$];
    logic [31:0] hist [$];
    logic [32:0] exp_q [$];
    int          lat_q [$];
    logic [31:0] last_out;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input int n);
        logic [31:0] acc = '0;
        for (int j = 0; j < 11 && j <= n; j++) acc += tap_mem[j] * hist[n - j];
        return acc;
    endfunction

    // Output monitor: samples mid-cycle, pops the scoreboard on each sm handshake.
    logic        prev_vld = 1'b0;
    logic        prev_rdy = 1'b0;
    logic        prev_last;
    logic [31:0] prev_data;
    always @(negedge clk) begin
        if (rst) begin
            prev_vld = 1'b0;
        end else begin
            if (sm_tvalid && !prev_vld) begin
                if (lat_q.size() == 0) chk("latency_unexpected", 64'(lat_q.size()), 64'd1);
                else chk("latency", 64'(cyc - lat_q.pop_front()), 64'd13);
            end
            if (sm_tvalid && prev_vld && !prev_rdy) begin
                chk("hold_data", 64'(sm_tdata), 64'(prev_data));
                chk("hold_last", 64'(sm_tlast), 64'(prev_last));
            end
            if (sm_tvalid && !sm_tready) chk("bp_ss_tready", 64'(ss_tready), 64'd0);
            if (sm_tvalid && sm_tready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 64'(exp_q.size()), 64'd1);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("y_data", 64'(sm_tdata), 64'(e[31:0]));
                    chk("y_last", 64'(sm_tlast), 64'(e[32]));
                    last_out = sm_tdata;
                end
            end
            prev_vld  = sm_tvalid;
            prev_rdy  = sm_tready;
            prev_data = sm_tdata;
            prev_last = sm_tlast;
        end
    end

    task automatic start(input int len);
        data_length = 32'(len);
        ap_start    = 1'b1;
        step();
        ap_start    = 1'b0;
        chk("busy_after_start", 64'(ap_idle), 64'd0);
    endtask

    task automatic send(input logic [31:0] x);
        int n = 0;
        ss_tdata  = x;
        ss_tvalid = 1'b1;
        while (!ss_tready && n < 200) begin
            step();
            n++;
        end
        if (!ss_tready) begin
            chk("ss_tready_timeout", 64'(ss_tready), 64'd1);
        end else begin
            hist.push_back(x);
            exp_q.push_back({(hist.size() == cur_len), model(hist.size() - 1)});
            lat_q.push_back(cyc);
        end
        step();
        ss_tvalid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!ap_done && n < 300) begin
            step();
            n++;
        end
        chk("ap_done_seen", 64'(ap_done), 64'd1);
        step();
        chk("ap_done_pulse", 64'(ap_done), 64'd0);
        chk("idle_after_done", 64'(ap_idle), 64'd1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run(input int len);
        hist.delete();
        cur_len = len;
        start(len);
        for (int i = 0; i < len; i++) send(stim[i]);
        wait_done();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ap_start = 1'b0; data_length = '0;
        ss_tvalid = 1'b0; ss_tdata = '0; sm_tready = 1'b1;
        for (int i = 0; i < 11; i++) tap_mem[i] = 32'(i + 1);
        repeat (3) step();
        rst = 1'b0;

        chk("rst_ap_idle", 64'(ap_idle), 64'd1);
        chk("rst_ap_done", 64'(ap_done), 64'd0);
        chk("rst_ss_tready", 64'(ss_tready), 64'd0);
        chk("rst_sm_tvalid", 64'(sm_tvalid), 64'd0);
        chk("rst_sm_tlast", 64'(sm_tlast), 64'd0);
        chk("rst_sm_tdata", 64'(sm_tdata), 64'd0);
        chk("rst_tap_re", 64'(tap_re), 64'd0);
        chk("rst_dat_re", 64'(dat_re), 64'd0);
        chk("rst_dat_we", 64'(dat_we), 64'd0);
        chk("rst_addrs", 64'({tap_raddr, dat_raddr, dat_waddr}), 64'd0);

        // Impulse: taps 1..11 reproduce themselves, then zeros.
        stim.delete();
        stim.push_back(32'd1);
        for (int i = 1; i < 15; i++) stim.push_back(32'd0);
        run(15);

        // Step: unit taps, constant 2 input, pointer wraps past 11.
        for (int i = 0; i < 11; i++) tap_mem[i] = 32'd1;
        stim.delete();
        for (int i = 0; i < 12; i++) stim.push_back(32'd2);
        run(12);

        // Backpressure: hold sm_tready low five cycles per output.
        hist.delete();
        cur_len = 2;
        stim.delete();
        stim.push_back(32'd3);
        stim.push_back(32'hFFFF_FFFF);
        sm_tready = 1'b0;
        start(2);
        for (int i = 0; i < 2; i++) begin
            int n = 0;
            send(stim[i]);
            while (!sm_tvalid && n < 40) begin
                step();
                n++;
            end
            chk("bp_valid_seen", 64'(sm_tvalid), 64'd1);
            repeat (5) step();
            sm_tready = 1'b1;
            step();
            sm_tready = 1'b0;
        end
        sm_tready = 1'b1;
        wait_done();

        // Overflow: single large tap times large sample wraps to 1.
        for (int i = 0; i < 11; i++) tap_mem[i] = 32'd0;
        tap_mem[0] = 32'h7FFF_FFFF;
        stim.delete();
        stim.push_back(32'h7FFF_FFFF);
        run(1);
        chk("ovf_wrap", 64'(last_out), 64'h1);

        // Reset mid-CALC, then a fresh run must not see stale data.
        for (int i = 0; i < 11; i++) tap_mem[i] = 32'(i + 1);
        stim.delete();
        stim.push_back(32'd5);
        stim.push_back(32'hFFFF_FFFD);
        stim.push_back(32'd7);
        hist.delete();
        cur_len = 3;
        start(3);
        send(32'd9);
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        lat_q.delete();
        chk("midrst_idle", 64'(ap_idle), 64'd1);
        chk("midrst_sm_tvalid", 64'(sm_tvalid), 64'd0);
        chk("midrst_dat_re", 64'(dat_re), 64'd0);
        run(3);

        // Zero length: done right after the clear pass, never ready for input.
        begin
            int n = 0;
            logic saw_ready = 1'b0;
            start(0);
            while (!ap_done && n < 40) begin
                saw_ready |= ss_tready;
                step();
                n++;
            end
            chk("len0_done", 64'(ap_done), 64'd1);
            chk("len0_latency", 64'(n), 64'd11);
            chk("len0_no_ready", 64'(saw_ready), 64'd0);
            step();
            chk("len0_pulse", 64'(ap_done), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
